// File: rtl/dmem_access_unit_pkg.sv
// Shared types for the data-memory port stage: read-origin tag and the captured EX request.
package dmem_access_unit_pkg;

  typedef enum logic {
    ORG_PIPE = 1'b0,
    ORG_TEST = 1'b1
  } mem_origin_t;

  typedef struct packed {
    logic        csb;
    logic        web;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;

  function automatic logic is_read(input logic csb, input logic web);
    return (csb == 1'b0) && (web == 1'b1);
  endfunction

endpackage

// File: rtl/dmem_access_unit_tracker.sv
// Read-latency tracker: a READ_LAT-deep shift line of {valid, origin}; the last stage marks
// the cycle in which the SRAM presents data for a read issued READ_LAT cycles earlier.
module rd_latency_tracker
  import dmem_access_unit_pkg::*;
#(
  parameter int READ_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue,
  input  mem_origin_t origin,
  output logic        done_pipe,
  output logic        done_test
);

  logic [READ_LAT-1:0] vld_q;
  mem_origin_t         org_q [READ_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < READ_LAT; i++) org_q[i] <= ORG_PIPE;
    end else begin
      vld_q[0] <= issue;
      org_q[0] <= origin;
      for (int i = 1; i < READ_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        org_q[i] <= org_q[i-1];
      end
    end
  end

  assign done_pipe = vld_q[READ_LAT-1] && (org_q[READ_LAT-1] == ORG_PIPE);
  assign done_test = vld_q[READ_LAT-1] && (org_q[READ_LAT-1] == ORG_TEST);

endmodule

// File: rtl/dmem_access_unit.sv
// Data-memory port stage: muxes the SRAM between the EX request and the startup self-test,
// holds the request across stalls, and routes read data back by the origin tagged at issue.
module dmem_access_unit
  import dmem_access_unit_pkg::*;
#(
  parameter int               ADDR_W       = 10,
  parameter int               READ_LAT     = 2,
  parameter logic [ADDR_W-1:0] TEST_ADDR   = 10'h001,
  parameter logic [31:0]      TEST_PATTERN = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              test_en,
  input  logic              test_mem_csb,
  input  logic              test_mem_we,
  input  logic              enable_cs,
  input  logic              stop_pipelinen,
  input  logic              csb_ex,
  input  logic              web_ex,
  input  logic [31:0]       addr_ex,
  input  logic [31:0]       wdata_ex,
  input  logic [31:0]       mem_rdata,
  output logic              mem_csb,
  output logic              mem_web,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [31:0]       rdata_mem,
  output logic              rdata_valid,
  output logic [31:0]       test_mem_data
);

  dmem_req_t   req_q;
  dmem_req_t   req_src;
  mem_origin_t issue_origin;
  logic        rd_issue;
  logic        done_pipe;
  logic        done_test;
  logic        unused_addr_bits;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q <= '0;
    end else if (stop_pipelinen && !test_en) begin
      req_q <= '{csb: csb_ex, web: web_ex, addr: addr_ex, wdata: wdata_ex};
    end
  end

  // While stalled the SRAM keeps seeing the request captured before the stall.
  always_comb begin
    req_src = req_q;
    if (stop_pipelinen) req_src = '{csb: csb_ex, web: web_ex, addr: addr_ex, wdata: wdata_ex};
  end

  // Only the word index reaches the SRAM; byte offset and high bits wrap silently.
  assign unused_addr_bits = ^{req_src.addr[1:0], req_src.addr[31:ADDR_W+2]};

  always_comb begin
    mem_csb   = 1'b1;
    mem_web   = 1'b1;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!rst) begin
      if (test_en) begin
        mem_csb   = ~test_mem_csb;
        mem_web   = ~test_mem_we;
        mem_addr  = TEST_ADDR;
        mem_wdata = TEST_PATTERN;
      end else begin
        mem_csb   = req_src.csb | enable_cs;
        mem_web   = req_src.web;
        mem_addr  = req_src.addr[ADDR_W+1:2];
        mem_wdata = req_src.wdata;
      end
    end
  end

  assign rd_issue     = is_read(mem_csb, mem_web);
  assign issue_origin = test_en ? ORG_TEST : ORG_PIPE;

  rd_latency_tracker #(
    .READ_LAT (READ_LAT)
  ) u_tracker (
    .clk       (clk),
    .rst       (rst),
    .issue     (rd_issue),
    .origin    (issue_origin),
    .done_pipe (done_pipe),
    .done_test (done_test)
  );

  // rdata_valid is a one-cycle strobe with no ready: MEM/WB samples rdata_mem in that cycle,
  // and the value stays held until the next pipeline load completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_mem     <= '0;
      rdata_valid   <= 1'b0;
      test_mem_data <= '0;
    end else begin
      rdata_valid <= done_pipe;
      if (done_pipe) rdata_mem <= mem_rdata;
      if (done_test) test_mem_data <= mem_rdata;
    end
  end

endmodule
